mem_arbiter_2m: RTL and testbench
=================================

// Module: mem_arbiter_2m
// PURPOSE
//  Shares one single-port synchronous word RAM between two masters using the native mem_valid/mem_ready protocol
//  (master 0 = CPU core, master 1 = loader/DMA). Sits between the cores and the on-chip RAM in the SoC top.
//  Arbitrates requests, sequences the RAM access and returns read data with a one-cycle ready pulse.
//  Addresses at or above the RAM size complete as bus errors without touching the RAM.
// PARAMETERS
//  MEM_WORDS  256  RAM depth in 32-bit words (power of 2); byte range 0 .. 4*MEM_WORDS-1
//  FIXED_PRI  0    0 = round-robin; 1 = master 0 always wins ties
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  reset      in   1         synchronous, active-high
//  mN_valid   in   1         N=0,1: request; held high until mN_ready
//  mN_addr    in   32        byte address; bits [1:0] ignored
//  mN_wdata   in   32        write data
//  mN_wstrb   in   4         byte enables; 0 = read
//  mN_ready   out  1         one-cycle completion pulse
//  mN_rdata   out  32        read data; valid while mN_ready=1
//  ram_en     out  1         RAM access strobe
//  ram_we     out  4         RAM byte write enables (copy of winning wstrb)
//  ram_addr   out  log2(MEM_WORDS)  word address = addr[AW+1:2]
//  ram_wdata  out  32        RAM write data
//  ram_rdata  in   32        RAM read data; valid in the cycle after ram_en
//  bus_err    out  1         one-cycle pulse, coincident with ready of an out-of-range access
//  grant      out  1         owner of the current/last transaction (0/1)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; RR pointer set so master 0 wins the first tie. A reset mid-transaction aborts
//   it: no ready is issued, ram_en drops in the next cycle, and a partially issued write is not retried.
//  FSM (all outputs registered):
//   IDLE   -> ACCESS when any mN_valid=1 and mN_ready=0. Latch winner, addr, wdata, wstrb.
//             In range: ram_en=1 for one cycle. Out of range: ram_en stays 0.
//   ACCESS -> WAIT   unconditionally; ram_en deasserted.
//   WAIT   -> ACK    capture ram_rdata (in range, read). Write or out of range: rdata=0.
//   ACK    -> IDLE   mWIN_ready=1 and mWIN_rdata driven for exactly 1 cycle; bus_err=1 if out of range.
//  Latency: valid sampled at edge E0 -> ram_en in cycle E0..E1 -> ready in cycle E2..E3 (3 cycles).
//   Throughput is 1 transfer per 4 cycles.
//  The ACK->IDLE edge never grants a master whose ready is high, so a held valid is not double-counted.
//  Arbitration, applied only in IDLE:
//   - Single requester wins.
//   - Both requesting: RR grants the master that did not own the last transaction; FIXED_PRI=1 grants m0.
//   - Under RR, continuous requests from both alternate 0,1,0,1.
//  The non-granted master waits with ready=0, without bound under FIXED_PRI=1.
//  Width rules:
//   - in_range = (addr >> 2) < MEM_WORDS, computed on the full 32-bit address; no wrap-around.
//   - ram_addr is truncated only after the range check.
//  Protocol violation: if valid drops mid-transaction, the access still completes and ready still pulses.
//  Outputs of the idle master stay 0; mN_rdata = 0 except during its ready pulse.
// STRUCTURE
//  Package mem_bus_pkg: FSM state encodings (IDLE/ACCESS/WAIT/ACK), WORD_W=32, STRB_W=4,
//   and a clog2 helper for ram_addr width.
//  Sub-module rr_arb2: combinational 2-way round-robin/fixed grant + registered last-owner pointer.
//  Top level holds the FSM, request latch, range check and response registers.
// TESTING
//  1 Single read: preload RAM[5]=0xDEADBEEF; m0 read 0x14 -> ram_en at +1 cycle with ram_addr=5;
//    m0_ready at +3 cycles with rdata=0xDEADBEEF.
//  2 Byte write: m1 write 0x3FC, wdata=0x11223344, wstrb=0100 -> ram_we=0100, ram_addr=255;
//    m1_ready at +3 cycles with rdata=0; a readback gives only byte 2 = 0x22 changed.
//  3 Contention: both valid from reset, held for 4 transactions -> grants 0,1,0,1 (RR);
//    with FIXED_PRI=1, m0 is granted all 4 while m1_ready stays 0.
//  4 Out of range: m0 read 0x400 (MEM_WORDS=256) -> ram_en never 1; m0_ready and bus_err both pulse at +3 cycles; rdata=0.
//  5 Reset mid-op: assert reset in the WAIT cycle -> no ready pulse and all outputs 0 next cycle;
//    a re-issued request completes normally with 3-cycle latency.
//  6 CPU program: drive the li/sw/lw/addi/sw/j loop on m0 with m1 idle -> RAM word 255 increments 1,2,3...
//    Every m0 transaction takes exactly 4 cycles from grant to IDLE.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory arbiter.
//
// Contents:
//   WORD_W      - data/address word width (32)
//   STRB_W      - byte-enable width (4)
//   bus_state_t - arbiter sequencing states (IDLE/ACCESS/WAIT/ACK)
//   clog2()     - ceiling log2, used to size the RAM word address
package mem_bus_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } bus_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter with a registered last-owner pointer.
//
// Ports:
//   clk      in   clock, all state on posedge
//   reset    in   synchronous active-high reset
//   req      in   [1:0] request per master
//   advance  in   a grant is being taken this cycle; remember its owner
//   gnt      out  index of the winning master (combinational)
//
// With FIXED_PRI=0 a tie goes to the master that did not own the last
// transaction; with FIXED_PRI=1 master 0 always wins a tie.
module rr_arb2 #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt
);

    logic last_owner;

    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = FIXED_PRI ? 1'b0 : ~last_owner;
            default: gnt = 1'b0;
        endcase
    end

    // Pointer starts at master 1 so that master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (advance) begin
            last_owner <= gnt;
        end
    end

endmodule

// File: rtl/mem_arbiter_2m.sv
// Shares one single-port synchronous word RAM between two masters using the
// valid/ready protocol (master 0 = CPU, master 1 = loader/DMA). Each access
// runs IDLE -> ACCESS -> WAIT -> ACK; out-of-range addresses complete with a
// bus error and never strobe the RAM.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   mN_valid/addr/wdata/wstrb   request from master N (wstrb=0 means read)
//   mN_ready/rdata          one-cycle completion pulse and read data
//   ram_en/we/addr/wdata    RAM access strobe, byte enables, word address, data
//   ram_rdata               RAM read data, valid the cycle after ram_en
//   bus_err                 pulses with ready of an out-of-range access
//   grant                   owner of the current/last transaction
module mem_arbiter_2m
    import mem_bus_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter bit FIXED_PRI = 1'b0,
    localparam int AW = clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [WORD_W-1:0] m0_addr,
    input  logic [WORD_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [WORD_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [WORD_W-1:0] m1_addr,
    input  logic [WORD_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [WORD_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic [STRB_W-1:0] ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              bus_err,
    output logic              grant
);

    bus_state_t state, state_next;

    logic              grant_next;
    logic              oor, oor_next;
    logic [STRB_W-1:0] wstrb_q, wstrb_next;
    logic              ram_en_next;
    logic [STRB_W-1:0] ram_we_next;
    logic [AW-1:0]     ram_addr_next;
    logic [WORD_W-1:0] ram_wdata_next;
    logic              m0_ready_next, m1_ready_next;
    logic [WORD_W-1:0] m0_rdata_next, m1_rdata_next;
    logic              bus_err_next;

    logic [1:0]        req;
    logic              arb_gnt;
    logic              arb_advance;
    logic [WORD_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic [WORD_W-1:0] sel_word;
    logic              sel_in_range;
    logic [WORD_W-1:0] resp_data;

    // A master whose ready is high is finishing; masking it keeps a held
    // valid from being granted twice for the same request.
    assign req         = {m1_valid & ~m1_ready, m0_valid & ~m0_ready};
    assign arb_advance = (state == IDLE) && (req != 2'b00);

    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    assign sel_addr  = arb_gnt ? m1_addr  : m0_addr;
    assign sel_wdata = arb_gnt ? m1_wdata : m0_wdata;
    assign sel_wstrb = arb_gnt ? m1_wstrb : m0_wstrb;

    // Range check on the full word index before truncating to the RAM
    // address, so high addresses cannot alias into the RAM.
    assign sel_word     = sel_addr >> 2;
    assign sel_in_range = sel_word < 32'(MEM_WORDS);

    assign resp_data = (!oor && (wstrb_q == '0)) ? ram_rdata : '0;

    // Next-state and next-output logic. Strobes and read data default to
    // zero so each is a single-cycle pulse; request latches hold.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        oor_next       = oor;
        wstrb_next     = wstrb_q;
        ram_en_next    = 1'b0;
        ram_we_next    = '0;
        ram_addr_next  = ram_addr;
        ram_wdata_next = ram_wdata;
        m0_ready_next  = 1'b0;
        m1_ready_next  = 1'b0;
        m0_rdata_next  = '0;
        m1_rdata_next  = '0;
        bus_err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next     = ACCESS;
                    grant_next     = arb_gnt;
                    oor_next       = ~sel_in_range;
                    wstrb_next     = sel_wstrb;
                    ram_en_next    = sel_in_range;
                    ram_we_next    = sel_in_range ? sel_wstrb : '0;
                    ram_addr_next  = sel_word[AW-1:0];
                    ram_wdata_next = sel_wdata;
                end
            end
            ACCESS: begin
                state_next = WAIT;
            end
            WAIT: begin
                state_next   = ACK;
                bus_err_next = oor;
                if (grant) begin
                    m1_ready_next = 1'b1;
                    m1_rdata_next = resp_data;
                end else begin
                    m0_ready_next = 1'b1;
                    m0_rdata_next = resp_data;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 1'b0;
            oor       <= 1'b0;
            wstrb_q   <= '0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            oor       <= oor_next;
            wstrb_q   <= wstrb_next;
            ram_en    <= ram_en_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
            m0_ready  <= m0_ready_next;
            m1_ready  <= m1_ready_next;
            m0_rdata  <= m0_rdata_next;
            m1_rdata  <= m1_rdata_next;
            bus_err   <= bus_err_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// Bench for mem_arbiter_2m: a round-robin instance carries all traffic, a
// fixed-priority instance is exercised under contention. Expected results
// come from a word-array memory model updated by the byte-enable rules.
module tb_mem_arbiter_2m;

    localparam int MEM_WORDS = 256;
    localparam int AW        = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        bus_err, grant;

    logic        fx_m0_valid, fx_m1_valid;
    logic        fx_m0_ready, fx_m1_ready;
    logic [31:0] fx_m0_rdata, fx_m1_rdata;
    logic        fx_ram_en;
    logic [3:0]  fx_ram_we;
    logic [AW-1:0] fx_ram_addr;
    logic [31:0] fx_ram_wdata, fx_ram_rdata;
    logic        fx_bus_err, fx_grant;

    logic [31:0] ram_arr [MEM_WORDS];
    logic [31:0] fx_ram [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        load_req;

    int total = 0;
    int bad   = 0;

    mem_arbiter_2m #(.MEM_WORDS(MEM_WORDS), .FIXED_PRI(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .bus_err(bus_err), .grant(grant)
    );

    mem_arbiter_2m #(.MEM_WORDS(MEM_WORDS), .FIXED_PRI(1'b1)) dut_fx (
        .clk(clk), .reset(reset),
        .m0_valid(fx_m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(fx_m0_ready), .m0_rdata(fx_m0_rdata),
        .m1_valid(fx_m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(fx_m1_ready), .m1_rdata(fx_m1_rdata),
        .ram_en(fx_ram_en), .ram_we(fx_ram_we), .ram_addr(fx_ram_addr), .ram_wdata(fx_ram_wdata),
        .ram_rdata(fx_ram_rdata), .bus_err(fx_bus_err), .grant(fx_grant)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Synchronous RAMs behind each arbiter, preloaded from the reference image.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                ram_arr[i] <= ref_mem[i];
                fx_ram[i]  <= ref_mem[i];
            end
        end else begin
            if (ram_en) begin
                if (ram_we != 4'd0) ram_arr[ram_addr] <= merge(ram_arr[ram_addr], ram_wdata, ram_we);
                ram_rdata <= ram_arr[ram_addr];
            end
            if (fx_ram_en) begin
                if (fx_ram_we != 4'd0) fx_ram[fx_ram_addr] <= merge(fx_ram[fx_ram_addr], fx_ram_wdata, fx_ram_we);
                fx_ram_rdata <= fx_ram[fx_ram_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One transaction from a single master, called at a negedge with the DUT idle.
    task automatic applyStimulus(input int mst, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output logic [31:0] got);
        logic        in_rng;
        logic [31:0] exp_rd;
        int          idx, cyc, en_cnt, other_rdy;
        logic        done, en1, err_seen;
        logic [AW-1:0] addr1;
        logic [3:0]  we1;
        logic [31:0] wd1;
        idx    = int'(addr >> 2) % MEM_WORDS;
        in_rng = (addr >> 2) < 32'(MEM_WORDS);
        exp_rd = (in_rng && wstrb == 4'd0) ? ref_mem[idx] : 32'd0;
        if (mst == 0) begin
            m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
        end else begin
            m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
        end
        cyc = 0; en_cnt = 0; other_rdy = 0; done = 1'b0; en1 = 1'b0; err_seen = 1'b0;
        addr1 = '0; we1 = '0; wd1 = '0; got = '0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                en1 = ram_en; addr1 = ram_addr; we1 = ram_we; wd1 = ram_wdata;
            end
            if (ram_en) en_cnt++;
            if ((mst == 0) ? m1_ready : m0_ready) other_rdy++;
            if ((mst == 0) ? m0_ready : m1_ready) begin
                done     = 1'b1;
                got      = (mst == 0) ? m0_rdata : m1_rdata;
                err_seen = bus_err;
            end
        end
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("latency", cyc, 3);
        checkOutput("ram_en_count", en_cnt, 32'(in_rng));
        checkOutput("ram_en_cycle1", 32'(en1), 32'(in_rng));
        if (in_rng) begin
            checkOutput("ram_addr", 32'(addr1), idx);
            checkOutput("ram_we", 32'(we1), 32'(wstrb));
            if (wstrb != 4'd0) checkOutput("ram_wdata", wd1, wdata);
        end
        checkOutput("rdata", got, exp_rd);
        checkOutput("bus_err", 32'(err_seen), 32'(!in_rng));
        checkOutput("grant", 32'(grant), mst);
        checkOutput("other_ready", other_rdy, 0);
        if (in_rng && wstrb != 4'd0) ref_mem[idx] = merge(ref_mem[idx], wdata, wstrb);
        @(negedge clk);
        if (mst == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_pulse", {29'd0, m0_ready, m1_ready, bus_err}, 32'd0);
        checkOutput("rdata_idle", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] g, old_w, x1, addr;
        int k, fx0, fx1, owner, rdy_cnt, mst;
        logic [3:0] strb;

        reset = 1'b1; load_req = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0; fx_m0_valid = 1'b0; fx_m1_valid = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[5] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {24'd0, m0_ready, m1_ready, ram_en, bus_err, grant, 3'd0}, 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_rdata", m0_rdata | m1_rdata, 32'd0);

        // Contention from reset: both masters hold valid for four transactions.
        @(negedge clk);
        reset = 1'b0; load_req = 1'b0;
        m0_addr = 32'h10; m1_addr = 32'h20;
        m0_valid = 1'b1; m1_valid = 1'b1; fx_m0_valid = 1'b1; fx_m1_valid = 1'b1;
        k = 0; fx0 = 0; fx1 = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (m0_ready || m1_ready) begin
                owner = m1_ready ? 1 : 0;
                checkOutput("rr_owner", owner, k % 2);
                checkOutput("rr_grant", 32'(grant), owner);
                checkOutput("rr_rdata", owner ? m1_rdata : m0_rdata, ref_mem[owner ? 8 : 4]);
                k++;
            end
            if (fx_m0_ready) begin
                fx0++;
                checkOutput("fx_rdata", fx_m0_rdata, ref_mem[4]);
            end
            if (fx_m1_ready) fx1++;
        end
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0; fx_m0_valid = 1'b0; fx_m1_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rr_count", k, 4);
        checkOutput("fx_m0_count", fx0, 4);
        checkOutput("fx_m1_count", fx1, 0);
        checkOutput("fx_grant", 32'(fx_grant), 32'd0);

        // Single read, byte write with readback, out-of-range accesses.
        applyStimulus(0, 32'h14, 32'h0, 4'h0, g);
        checkOutput("read_deadbeef", g, 32'hDEADBEEF);
        old_w = ref_mem[255];
        applyStimulus(1, 32'h3FC, 32'h11223344, 4'b0100, g);
        applyStimulus(0, 32'h3FC, 32'h0, 4'h0, g);
        checkOutput("byte2_value", 32'(g[23:16]), 32'h22);
        checkOutput("other_bytes", g & 32'hFF00FFFF, old_w & 32'hFF00FFFF);
        applyStimulus(0, 32'h400, 32'h0, 4'h0, g);
        applyStimulus(1, 32'h4000_0014, 32'hCAFEF00D, 4'hF, g);

        // Reset during WAIT aborts the access without a ready pulse.
        m1_addr = 32'h20; m1_wstrb = 4'h0; m1_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; m1_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_ctrl", {27'd0, m0_ready, m1_ready, ram_en, bus_err, grant}, 32'd0);
        checkOutput("abort_bus", {ram_we, 20'd0, ram_addr}, 32'd0);
        checkOutput("abort_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (m0_ready || m1_ready) rdy_cnt++;
        end
        checkOutput("abort_no_ready", rdy_cnt, 0);
        @(negedge clk);
        applyStimulus(1, 32'h20, 32'h0, 4'h0, g);

        // CPU loop: li x1,0 / sw / lw / addi / sw / j, counter at word 255.
        applyStimulus(0, 32'h00, 32'h0, 4'h0, g);
        x1 = 32'd0;
        applyStimulus(0, 32'h04, 32'h0, 4'h0, g);
        applyStimulus(0, 32'h3FC, x1, 4'hF, g);
        for (int it = 1; it <= 5; it++) begin
            applyStimulus(0, 32'h08, 32'h0, 4'h0, g);
            applyStimulus(0, 32'h3FC, 32'h0, 4'h0, x1);
            checkOutput("cpu_count", x1, it - 1);
            applyStimulus(0, 32'h0C, 32'h0, 4'h0, g);
            x1 = x1 + 32'd1;
            applyStimulus(0, 32'h10, 32'h0, 4'h0, g);
            applyStimulus(0, 32'h3FC, x1, 4'hF, g);
            applyStimulus(0, 32'h14, 32'h0, 4'h0, g);
        end
        applyStimulus(0, 32'h3FC, 32'h0, 4'h0, g);
        checkOutput("cpu_final", g, 32'd5);

        // Randomized single-master traffic, including out-of-range addresses.
        for (int n = 0; n < 40; n++) begin
            mst = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr = 32'h400 + ($urandom_range(0, 255) << 2);
                1:       addr = $urandom | 32'h8000_0000;
                default: addr = $urandom_range(0, 1023);
            endcase
            strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            applyStimulus(mst, addr, $urandom, strb, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
